set_bit_iterator: RTL and testbench

- Streams the set bits of a WIDTH-bit vector, one per beat, LSB first, over a valid/ready handshake.
- Each beat carries the binary position, the one-hot form and the 1-based ordinal of the set bit.
- Beat k's one-hot equals the k-th set bit from LSB, so beat 2 matches the second-set-bit finder's output.
- Sits after vector sources (request masks, interrupt pending words) to serialize them into per-bit events.

---
 rtl/set_bit_iterator.sv | 107 ++++++++++
 tb/tb_set_bit_iterator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/set_bit_iterator.sv
// set_bit_iterator: serializes the set bits of a vector, LSB first,
// one beat per valid/ready handshake with position, one-hot and ordinal.
module set_bit_iterator #(
  parameter int WIDTH = 12,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] vec_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [IDX_W-1:0] pos_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] rem_rest;
  logic             is_last;

  // lowest set bit, and what remains once it is consumed
  always_comb begin
    low_bit  = rem_q & (~rem_q + ONE_W);
    rem_rest = rem_q & (rem_q - ONE_W);
    is_last  = (rem_rest == '0);
  end

  // state, remaining bits and ordinal registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: capture in IDLE, consume one bit per handshake in EMIT
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          rem_d   = vec_i;
          cnt_d   = ONE_C;
          state_d = (vec_i != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (ready_i) begin
          rem_d = rem_rest;
          if (is_last) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // beat outputs decode only from registered state
  always_comb begin
    busy_o   = (state_q != IDLE);
    done_o   = (state_q == DONE);
    valid_o  = 1'b0;
    onehot_o = '0;
    pos_o    = '0;
    count_o  = '0;
    last_o   = 1'b0;
    if (state_q == EMIT) begin
      valid_o  = 1'b1;
      onehot_o = low_bit;
      count_o  = cnt_q;
      last_o   = is_last;
      for (int i = 0; i < WIDTH; i++) begin
        if (low_bit[i]) pos_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// tb_set_bit_iterator: directed and random streams checked against
// a list of set-bit indices built from the loaded vector.
module tb_set_bit_iterator;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_i;
  logic [11:0] vec_i;
  logic        busy_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  pos_o;
  logic [11:0] onehot_o;
  logic [3:0]  count_o;
  logic        last_o;
  logic        done_o;

  int n_vec = 0;
  int n_err = 0;

  set_bit_iterator #(.WIDTH(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_i),
    .vec_i    (vec_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .pos_o    (pos_o),
    .onehot_o (onehot_o),
    .count_o  (count_o),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".valid"}, valid_o, 0);
    chk({tag, ".pos"}, pos_o, 0);
    chk({tag, ".onehot"}, onehot_o, 0);
    chk({tag, ".count"}, count_o, 0);
    chk({tag, ".last"}, last_o, 0);
    chk({tag, ".done"}, done_o, 0);
  endtask

  // stall: leading cycles with ready low; rnd: random ready afterwards
  // inj: beat cycle at which a stray load is driven; rst: reset cycle
  task automatic run_vec(input logic [11:0] v, input int stall,
                         input bit rnd, input int inj, input int rst);
    int q[$];
    int k;
    int cyc;
    int beats;
    bit r;
    logic [11:0] one;
    for (int i = 0; i < 12; i++) if ((v >> i) & 12'd1) q.push_back(i);
    @(negedge clk);
    load_i = 1'b1;
    vec_i = v;
    ready_i = 1'b0;
    @(negedge clk);
    load_i = 1'b0;
    vec_i = $urandom;
    chk("busy_n1", busy_o, 1);
    if (q.size() == 0) begin
      chk("zero.done", done_o, 1);
      chk("zero.valid", valid_o, 0);
      @(negedge clk);
      chk("zero.busy2", busy_o, 0);
      chk("zero.done2", done_o, 0);
      return;
    end
    k = 0;
    cyc = 0;
    beats = 0;
    while (k < q.size() && cyc < 300) begin
      one = 12'd1 << q[k];
      chk("valid", valid_o, 1);
      chk("pos", pos_o, q[k]);
      chk("onehot", onehot_o, one);
      chk("count", count_o, k + 1);
      chk("last", last_o, (k == q.size() - 1));
      chk("done_mid", done_o, 0);
      if (k == 1) chk("beat2", onehot_o, 12'd1 << q[1]);
      if (cyc < stall) r = 1'b0;
      else if (rnd) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      ready_i = r;
      load_i = (cyc == inj);
      vec_i = (cyc == inj) ? 12'hF00 : 12'($urandom);
      if (cyc == rst) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ready_i = 1'b0;
        load_i = 1'b0;
        chk_zero("rst_mid");
        @(negedge clk);
        chk("rst_nodone", done_o, 0);
        chk("rst_idle", busy_o, 0);
        return;
      end
      @(negedge clk);
      load_i = 1'b0;
      if (r) begin
        k++;
        beats++;
      end
      cyc++;
    end
    ready_i = 1'b0;
    chk("timeout", (cyc < 300), 1);
    chk("popcount", beats, $countones(v));
    chk("end.done", done_o, 1);
    chk("end.valid", valid_o, 0);
    chk("end.busy", busy_o, 1);
    @(negedge clk);
    chk("idle.done", done_o, 0);
    chk("idle.busy", busy_o, 0);
  endtask

  initial begin
    reset = 1'b1;
    load_i = 1'b0;
    vec_i = '0;
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    run_vec(12'h052, 0, 1'b0, -1, -1);
    run_vec(12'hFFF, 0, 1'b0, -1, -1);
    run_vec(12'h000, 0, 1'b0, -1, -1);
    run_vec(12'h801, 3, 1'b0, -1, -1);
    run_vec(12'h00F, 0, 1'b0, 1, -1);
    run_vec(12'h00F, 0, 1'b0, -1, 1);
    for (int t = 0; t < 500; t++) begin
      logic [11:0] rv;
      rv = 12'($urandom);
      if ($urandom_range(0, 9) == 0) rv = '0;
      run_vec(rv, 0, 1'b1, -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
